// File: rtl/iob_fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream port of the FIFO stream reader.
// The master modport is the reader's own view; slave is the FIFO/consumer side.
interface iob_fifo_stream_reader_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
);
  logic              fifo_r_en;
  logic [DATA_W-1:0] fifo_r_data;
  logic              fifo_r_empty;
  logic              flush;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  buf_level;
  logic              busy;

  modport master (
    output fifo_r_en, m_valid, m_data, buf_level, busy,
    input  fifo_r_data, fifo_r_empty, flush, m_ready
  );

  modport slave (
    input  fifo_r_en, m_valid, m_data, buf_level, busy,
    output fifo_r_data, fifo_r_empty, flush, m_ready
  );
endinterface

// File: rtl/iob_fifo_stream_reader.sv
// Drains a synchronous FIFO read port with fixed read latency and presents the
// words as a valid/ready stream. Reads are issued ahead on credits so that
// every returning word has a guaranteed slot in a small circular skid buffer.
module iob_fifo_stream_reader #(
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int BUF_DEPTH    = READ_LATENCY + 1,
  parameter int CNT_W        = $clog2(BUF_DEPTH + 1)
) (
  input logic                      ap_clk,
  input logic                      rst,
  iob_fifo_stream_reader_if.master bus
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int SUM_W = CNT_W + 2;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] LVL_FULL  = CNT_W'(BUF_DEPTH);
  localparam logic [SUM_W-1:0] SUM_DEPTH = SUM_W'(BUF_DEPTH);

  logic [DATA_W-1:0]       mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]        level_q, level_d;
  logic [READ_LATENCY-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0]        inflight_cnt;
  logic [SUM_W-1:0]        credit_used;
  logic                    r_en;
  logic                    push;
  logic                    pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check, in-flight shift register and pointer/level next state
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(inflight_q[i]);
    end
    push = inflight_q[READ_LATENCY-1];
    pop  = (level_q != '0) && bus.m_ready;
    // A read may issue only if buffered + in-flight words, less the word
    // leaving this cycle, still leave a free slot for it.
    credit_used = SUM_W'(level_q) + SUM_W'(inflight_cnt);
    r_en = !rst && !bus.flush && !bus.fifo_r_empty &&
           (credit_used < SUM_DEPTH + SUM_W'(pop));

    inflight_d    = '0;
    inflight_d[0] = r_en;
    for (int i = 1; i < READ_LATENCY; i++) begin
      inflight_d[i] = inflight_q[i-1];
    end

    head_d  = pop  ? ptr_inc(head_q) : head_q;
    tail_d  = push ? ptr_inc(tail_q) : tail_q;
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + CNT_W'(1);
    end else if (!push && pop) begin
      level_d = level_q - CNT_W'(1);
    end

    // Flush drops everything buffered and anything still on its way back
    if (bus.flush) begin
      head_d     = '0;
      tail_d     = '0;
      level_d    = '0;
      inflight_d = '0;
    end
  end

  // Control state registers
  always_ff @(posedge ap_clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      level_q    <= '0;
      inflight_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
    end
  end

  // Skid buffer storage, written at the tail when a read returns
  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem_q[tail_q] <= bus.fifo_r_data;
    end
  end

  // Overflow guard: the credit rule must make this unreachable
  always_ff @(posedge ap_clk) begin
    if (!rst) begin
      assert (!(push && !pop && (level_q == LVL_FULL)))
        else $error("iob_fifo_stream_reader: skid buffer overflow");
    end
  end

  // Stream outputs come only from registered state; data reads as zero when
  // the buffer is empty so the reset value of m_data is defined.
  assign bus.fifo_r_en = r_en;
  assign bus.m_valid   = (level_q != '0);
  assign bus.m_data    = (level_q != '0) ? mem_q[head_q] : '0;
  assign bus.buf_level = level_q;
  assign bus.busy      = (level_q != '0) || (|inflight_q);

endmodule

// File: tb/tb_iob_fifo_stream_reader.sv
// Bench for iob_fifo_stream_reader: two instances (read latency 1 and 2) fed by
// behavioural registered FIFOs holding identical contents, sharing rst, flush
// and m_ready. Words written to the FIFOs are queued as expected stream output.
module tb_iob_fifo_stream_reader;
  localparam int DW = 32;
  localparam int CW = 2;

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic rst;
  logic flush;
  logic m_ready;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ren_viol = 0;

  iob_fifo_stream_reader_if #(.DATA_W(DW), .CNT_W(CW)) bus0 ();
  iob_fifo_stream_reader_if #(.DATA_W(DW), .CNT_W(CW)) bus1 ();

  iob_fifo_stream_reader #(.DATA_W(DW), .READ_LATENCY(1)) dut0 (
    .ap_clk(ap_clk), .rst(rst), .bus(bus0));
  iob_fifo_stream_reader #(.DATA_W(DW), .READ_LATENCY(2)) dut1 (
    .ap_clk(ap_clk), .rst(rst), .bus(bus1));

  logic          r_en    [2];
  logic          m_valid [2];
  logic [DW-1:0] m_data  [2];
  logic [CW-1:0] lvl     [2];
  logic          busy    [2];
  logic          r_empty [2] = '{1'b1, 1'b1};
  logic [DW-1:0] r_data0, r_data1, rp1;

  assign r_en[0] = bus0.fifo_r_en;   assign r_en[1] = bus1.fifo_r_en;
  assign m_valid[0] = bus0.m_valid;  assign m_valid[1] = bus1.m_valid;
  assign m_data[0] = bus0.m_data;    assign m_data[1] = bus1.m_data;
  assign lvl[0] = bus0.buf_level;    assign lvl[1] = bus1.buf_level;
  assign busy[0] = bus0.busy;        assign busy[1] = bus1.busy;
  assign bus0.fifo_r_data = r_data0; assign bus1.fifo_r_data = r_data1;
  assign bus0.fifo_r_empty = r_empty[0];
  assign bus1.fifo_r_empty = r_empty[1];
  assign bus0.flush = flush;         assign bus1.flush = flush;
  assign bus0.m_ready = m_ready;     assign bus1.m_ready = m_ready;

  logic [DW-1:0] src0[$], src1[$], exp0[$], exp1[$];
  int got   [2] = '{0, 0};
  int outst [2] = '{0, 0};

  function automatic int exp_size(input int l);
    return (l == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic logic [DW-1:0] exp_pop(input int l);
    if (l == 0) return exp0.pop_front();
    return exp1.pop_front();
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
  endtask

  // Behavioural FIFOs: registered read data (latency 1 and 2), registered empty
  always @(posedge ap_clk) begin
    logic [DW-1:0] w0, w1;
    w0 = '0;
    w1 = '0;
    if (r_en[0] === 1'b1 && src0.size() != 0) w0 = src0.pop_front();
    if (r_en[1] === 1'b1 && src1.size() != 0) w1 = src1.pop_front();
    r_data0 <= w0;
    rp1     <= w1;
    r_data1 <= rp1;
    r_empty[0] <= (src0.size() == 0);
    r_empty[1] <= (src1.size() == 0);
  end

  // Scoreboard: compare every accepted word, drop words lost to flush/reset
  always @(negedge ap_clk) begin
    for (int l = 0; l < 2; l++) begin
      if (r_en[l] === 1'b1 && r_empty[l] === 1'b1) ren_viol++;
      if (m_valid[l] === 1'b1 && m_ready === 1'b1) begin
        got[l]++;
        chk($sformatf("sb_has_expected_l%0d", l), (exp_size(l) != 0), 1);
        if (exp_size(l) != 0) chk($sformatf("sb_data_l%0d", l), m_data[l], exp_pop(l));
        outst[l]--;
      end
      if (r_en[l] === 1'b1) outst[l]++;
      if (flush === 1'b1 || rst === 1'b1) begin
        while (outst[l] > 0) begin
          void'(exp_pop(l));
          outst[l]--;
        end
        outst[l] = 0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] w);
    src0.push_back(w); src1.push_back(w);
    exp0.push_back(w); exp1.push_back(w);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || busy[0] !== 1'b0 ||
            busy[1] !== 1'b0) && k < 5000) begin
      tick();
      k++;
    end
    chk({tag, "_drain"}, (k < 5000), 1);
  endtask

  task automatic chk_reset(input string tag);
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("%s_ren_l%0d", tag, l), r_en[l], 0);
      chk($sformatf("%s_valid_l%0d", tag, l), m_valid[l], 0);
      chk($sformatf("%s_data_l%0d", tag, l), m_data[l], 0);
      chk($sformatf("%s_level_l%0d", tag, l), lvl[l], 0);
      chk($sformatf("%s_busy_l%0d", tag, l), busy[l], 0);
    end
  endtask

  initial begin
    int base0, base1, done0, done1, n_wr, k;
    logic [DW-1:0] wv;

    // Reset with FIFO preloaded
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    tick(); tick();
    wr(32'h11); wr(32'h22); wr(32'h33);
    tick(); tick();
    chk_reset("reset");

    // Basic drain: first word two cycles after deassert (three for latency 2)
    m_ready = 1'b1; rst = 1'b0;
    #1;
    chk("basic_ren_l0", r_en[0], 1);
    tick();
    chk("basic_c1_valid_l0", m_valid[0], 0);
    tick();
    chk("basic_c2_valid_l0", m_valid[0], 1);
    chk("basic_c2_data_l0", m_data[0], 32'h11);
    chk("basic_c2_valid_l1", m_valid[1], 0);
    tick();
    chk("basic_c3_data_l0", m_data[0], 32'h22);
    chk("basic_c3_valid_l1", m_valid[1], 1);
    chk("basic_c3_data_l1", m_data[1], 32'h11);
    tick();
    chk("basic_c4_data_l0", m_data[0], 32'h33);
    chk("basic_c4_data_l1", m_data[1], 32'h22);
    tick();
    chk("basic_c5_valid_l0", m_valid[0], 0);
    chk("basic_c5_busy_l0", busy[0], 0);
    chk("basic_c5_data_l1", m_data[1], 32'h33);
    tick();
    chk("basic_c6_valid_l1", m_valid[1], 0);
    chk("basic_c6_busy_l1", busy[1], 0);

    // Full rate: 64 words with a writer adding one word per cycle
    base0 = got[0]; base1 = got[1];
    wv = 32'h1000;
    wr(wv); wv++; n_wr = 1;
    tick();
    done0 = -1; done1 = -1;
    for (int c = 1; c <= 200 && (done0 < 0 || done1 < 0); c++) begin
      if (n_wr < 64) begin wr(wv); wv++; n_wr++; end
      tick();
      if (done0 < 0 && got[0] - base0 >= 64) done0 = c;
      if (done1 < 0 && got[1] - base1 >= 64) done1 = c;
    end
    chk("fullrate_cycles_l0", (done0 > 0 && done0 <= 64 + 1 + 1), 1);
    chk("fullrate_cycles_l1", (done1 > 0 && done1 <= 64 + 2 + 1), 1);
    wait_drain("fullrate");

    // Backpressure: 8 words held back for 10 cycles
    m_ready = 1'b0;
    base0 = got[0]; base1 = got[1];
    wv = 32'h2000;
    for (int i = 0; i < 8; i++) wr(wv + DW'(i));
    for (int i = 0; i < 10; i++) tick();
    chk("bp_level_l0", lvl[0], 2);
    chk("bp_level_l1", lvl[1], 3);
    chk("bp_ren_l0", r_en[0], 0);
    chk("bp_ren_l1", r_en[1], 0);
    chk("bp_hold_l0", m_data[0], wv);
    chk("bp_hold_l1", m_data[1], wv);
    m_ready = 1'b1;
    wait_drain("bp");
    chk("bp_count_l0", got[0] - base0, 8);
    chk("bp_count_l1", got[1] - base1, 8);

    // Random m_ready with a random writer, 1000 words
    base0 = got[0]; base1 = got[1];
    wv = 32'h10000; n_wr = 0;
    for (int c = 0; c < 20000 && n_wr < 1000; c++) begin
      if ($urandom_range(1, 0) == 1) begin wr(wv); wv++; n_wr++; end
      m_ready = ($urandom_range(1, 0) == 1);
      tick();
    end
    m_ready = 1'b1;
    wait_drain("random");
    chk("random_count_l0", got[0] - base0, 1000);
    chk("random_count_l1", got[1] - base1, 1000);

    // Flush the cycle after a read is issued; the returning word is dropped
    base0 = got[0]; base1 = got[1];
    wr(32'hA0); wr(32'hB0); wr(32'hC0);
    tick();
    chk("flush_ren_before_l0", r_en[0], 1);
    tick();
    flush = 1'b1;
    #1;
    chk("flush_ren_l0", r_en[0], 0);
    chk("flush_ren_l1", r_en[1], 0);
    tick();
    flush = 1'b0;
    chk("flush_after_valid_l0", m_valid[0], 0);
    chk("flush_after_valid_l1", m_valid[1], 0);
    chk("flush_after_level_l1", lvl[1], 0);
    chk("flush_after_busy_l1", busy[1], 0);
    wait_drain("flush");
    chk("flush_count_l0", got[0] - base0, 2);
    chk("flush_count_l1", got[1] - base1, 2);

    // Mid-stream reset with two words buffered and one read in flight
    m_ready = 1'b0;
    base0 = got[0]; base1 = got[1];
    wv = 32'h3000;
    for (int i = 0; i < 8; i++) wr(wv + DW'(i));
    k = 0;
    while (lvl[1] !== 2'd2 && k < 20) begin tick(); k++; end
    chk("midrst_pre_level_l1", lvl[1], 2);
    chk("midrst_pre_level_l0", lvl[0], 2);
    chk("midrst_pre_busy_l1", busy[1], 1);
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    m_ready = 1'b1;
    wait_drain("midrst");
    chk("midrst_count_l0", got[0] - base0, 6);
    chk("midrst_count_l1", got[1] - base1, 5);

    chk("ren_while_empty", ren_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
